// File: rtl/amplitude_ratio_meter_if.sv
// Sample-stream and result bus of amplitude_ratio_meter.
// master drives samples and observes results; slave is the meter.
interface amplitude_ratio_meter_if #(
  parameter int unsigned SAMPLE_SIZE         = 12,
  parameter int unsigned AMPLITUDE_DATA_SIZE = 16,
  parameter int unsigned RATIO_DATA_SIZE     = 8
);
  logic                           i_sampleValid;
  logic [SAMPLE_SIZE-1:0]         i_referenceSample;
  logic [SAMPLE_SIZE-1:0]         i_errorSample;
  logic [AMPLITUDE_DATA_SIZE-1:0] o_referenceAmplitude;
  logic [AMPLITUDE_DATA_SIZE-1:0] o_errorAmplitude;
  logic [RATIO_DATA_SIZE-1:0]     o_quotient;
  logic [RATIO_DATA_SIZE-1:0]     o_fractional;
  logic                           o_resultValid;
  logic                           o_busy;
  logic                           o_divByZero;

  modport master (
    output i_sampleValid, i_referenceSample, i_errorSample,
    input  o_referenceAmplitude, o_errorAmplitude, o_quotient, o_fractional,
    input  o_resultValid, o_busy, o_divByZero
  );

  modport slave (
    input  i_sampleValid, i_referenceSample, i_errorSample,
    output o_referenceAmplitude, o_errorAmplitude, o_quotient, o_fractional,
    output o_resultValid, o_busy, o_divByZero
  );
endinterface

// File: rtl/amplitude_ratio_meter.sv
// Windowed peak-to-peak amplitude meter with Q8.8 error/reference ratio via restoring divider.
// Optional macro AMPLITUDE_AVERAGE_EN: average each amplitude with the previous window's raw amplitude.
module amplitude_ratio_meter #(
  parameter int unsigned SAMPLE_SIZE         = 12,
  parameter int unsigned AMPLITUDE_DATA_SIZE = 16,
  parameter int unsigned RATIO_DATA_SIZE     = 8,
  parameter int unsigned WINDOW_SAMPLES      = 1024
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  amplitude_ratio_meter_if.slave bus
);
  localparam int unsigned SW    = SAMPLE_SIZE;
  localparam int unsigned AW    = AMPLITUDE_DATA_SIZE;
  localparam int unsigned RW    = RATIO_DATA_SIZE;
  localparam int unsigned NW    = AW + RW;
  localparam int unsigned CNT_W = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;
  localparam int unsigned BIT_W = $clog2(NW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_SAMPLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NW - 1);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_LATCH, S_DIVIDE, S_PUBLISH} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]   ref_min_q, ref_min_d, ref_max_q, ref_max_d;
  logic [SW-1:0]   err_min_q, err_min_d, err_max_q, err_max_d;
  logic [AW-1:0]   ref_amp_q, ref_amp_d, err_amp_q, err_amp_d;
  logic [NW-1:0]   num_q, num_d;
  logic [AW:0]     rem_q, rem_d;
  logic [AW-1:0]   div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic            dbz_pend_q, dbz_pend_d;
  logic [AW-1:0]   ref_out_q, ref_out_d, err_out_q, err_out_d;
  logic [RW-1:0]   quot_q, quot_d, frac_q, frac_d;
  logic            valid_q, valid_d, dbz_q, dbz_d;

  logic [SW-1:0]   ref_span, err_span;
  logic [AW-1:0]   ref_raw, err_raw, ref_use, err_use;
  logic [AW:0]     rem_shift;
  logic            ratio_ovf;

  assign ref_span  = ref_max_q - ref_min_q;
  assign err_span  = err_max_q - err_min_q;
  assign ref_raw   = AW'(ref_span);
  assign err_raw   = AW'(err_span);
  assign rem_shift = {rem_q[AW-1:0], num_q[NW-1]};
  assign ratio_ovf = (num_q >> (2 * RW)) != '0;

`ifdef AMPLITUDE_AVERAGE_EN
  logic [AW-1:0] prev_ref_q, prev_ref_d, prev_err_q, prev_err_d;
  logic          prev_valid_q, prev_valid_d;
  logic [AW:0]   ref_sum, err_sum;

  assign ref_sum = {1'b0, prev_ref_q} + {1'b0, ref_raw};
  assign err_sum = {1'b0, prev_err_q} + {1'b0, err_raw};
  assign ref_use = prev_valid_q ? ref_sum[AW:1] : ref_raw;
  assign err_use = prev_valid_q ? err_sum[AW:1] : err_raw;

  // History keeps raw amplitudes; disabling forgets it so a re-enabled run starts unaveraged.
  always_comb begin
    prev_ref_d   = prev_ref_q;
    prev_err_d   = prev_err_q;
    prev_valid_d = prev_valid_q;
    if (!i_enable) begin
      prev_valid_d = 1'b0;
    end else if (state_q == S_LATCH) begin
      prev_ref_d   = ref_raw;
      prev_err_d   = err_raw;
      prev_valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      prev_ref_q   <= '0;
      prev_err_q   <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      prev_ref_q   <= prev_ref_d;
      prev_err_q   <= prev_err_d;
      prev_valid_q <= prev_valid_d;
    end
  end
`else
  assign ref_use = ref_raw;
  assign err_use = err_raw;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ref_min_d  = ref_min_q;
    ref_max_d  = ref_max_q;
    err_min_d  = err_min_q;
    err_max_d  = err_max_q;
    ref_amp_d  = ref_amp_q;
    err_amp_d  = err_amp_q;
    num_d      = num_q;
    rem_d      = rem_q;
    div_d      = div_q;
    bit_d      = bit_q;
    dbz_pend_d = dbz_pend_q;
    ref_out_d  = ref_out_q;
    err_out_d  = err_out_q;
    quot_d     = quot_q;
    frac_d     = frac_q;
    dbz_d      = dbz_q;
    valid_d    = 1'b0;
    if (!i_enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ACCUM;
          cnt_d   = '0;
        end
        S_ACCUM: begin
          if (bus.i_sampleValid) begin
            if (cnt_q == '0) begin
              ref_min_d = bus.i_referenceSample;
              ref_max_d = bus.i_referenceSample;
              err_min_d = bus.i_errorSample;
              err_max_d = bus.i_errorSample;
            end else begin
              if (bus.i_referenceSample < ref_min_q) ref_min_d = bus.i_referenceSample;
              if (bus.i_referenceSample > ref_max_q) ref_max_d = bus.i_referenceSample;
              if (bus.i_errorSample < err_min_q) err_min_d = bus.i_errorSample;
              if (bus.i_errorSample > err_max_q) err_max_d = bus.i_errorSample;
            end
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = S_LATCH;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_LATCH: begin
          ref_amp_d  = ref_use;
          err_amp_d  = err_use;
          num_d      = {err_use, {RW{1'b0}}};
          rem_d      = '0;
          div_d      = ref_use;
          bit_d      = '0;
          dbz_pend_d = (ref_use == '0);
          state_d    = (ref_use == '0) ? S_PUBLISH : S_DIVIDE;
        end
        S_DIVIDE: begin
          // num_q shifts out numerator bits at the top and collects quotient bits at the bottom.
          if (rem_shift >= {1'b0, div_q}) begin
            rem_d = rem_shift - {1'b0, div_q};
            num_d = {num_q[NW-2:0], 1'b1};
          end else begin
            rem_d = rem_shift;
            num_d = {num_q[NW-2:0], 1'b0};
          end
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_LAST) state_d = S_PUBLISH;
        end
        S_PUBLISH: begin
          ref_out_d = ref_amp_q;
          err_out_d = err_amp_q;
          dbz_d     = dbz_pend_q;
          valid_d   = 1'b1;
          if (dbz_pend_q || ratio_ovf) begin
            quot_d = '1;
            frac_d = '1;
          end else begin
            quot_d = num_q[2*RW-1:RW];
            frac_d = num_q[RW-1:0];
          end
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ref_min_q  <= '0;
      ref_max_q  <= '0;
      err_min_q  <= '0;
      err_max_q  <= '0;
      ref_amp_q  <= '0;
      err_amp_q  <= '0;
      num_q      <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      dbz_pend_q <= 1'b0;
      ref_out_q  <= '0;
      err_out_q  <= '0;
      quot_q     <= '0;
      frac_q     <= '0;
      valid_q    <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_min_q  <= ref_min_d;
      ref_max_q  <= ref_max_d;
      err_min_q  <= err_min_d;
      err_max_q  <= err_max_d;
      ref_amp_q  <= ref_amp_d;
      err_amp_q  <= err_amp_d;
      num_q      <= num_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      dbz_pend_q <= dbz_pend_d;
      ref_out_q  <= ref_out_d;
      err_out_q  <= err_out_d;
      quot_q     <= quot_d;
      frac_q     <= frac_d;
      valid_q    <= valid_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.o_referenceAmplitude = ref_out_q;
  assign bus.o_errorAmplitude     = err_out_q;
  assign bus.o_quotient           = quot_q;
  assign bus.o_fractional         = frac_q;
  assign bus.o_resultValid        = valid_q;
  assign bus.o_divByZero          = dbz_q;
  assign bus.o_busy = (state_q == S_LATCH) || (state_q == S_DIVIDE) || (state_q == S_PUBLISH);
endmodule

// File: doc/amplitude_ratio_meter.md
Name: amplitude_ratio_meter

Overview:
- Upstream measurement stage for the IAGC UART logger.
- Tracks peak-to-peak amplitude of the reference and error sample streams over a fixed window of samples.
- Divides error amplitude by reference amplitude with a sequential restoring divider.
- Publishes both amplitudes and the ratio as 8-bit quotient plus 8-bit fractional (Q8.8). These drive the logger's amplitude, quotient and fractional inputs directly.

Parameters:
SAMPLE_SIZE, 12, width of unsigned input samples
AMPLITUDE_DATA_SIZE, 16, width of published amplitudes (must be >= SAMPLE_SIZE)
RATIO_DATA_SIZE, 8, width of quotient and of fractional outputs
WINDOW_SAMPLES, 1024, accepted samples per measurement window (>= 1)

Ports:
i_clock  input  1  system clock
i_reset  input  1  asynchronous active-high reset
i_enable  input  1  measurement enable
i_sampleValid  input  1  both samples valid this cycle
i_referenceSample  input  SAMPLE_SIZE  reference channel sample, unsigned
i_errorSample  input  SAMPLE_SIZE  error channel sample, unsigned
o_referenceAmplitude  output  AMPLITUDE_DATA_SIZE  last published reference max-min
o_errorAmplitude  output  AMPLITUDE_DATA_SIZE  last published error max-min
o_quotient  output  RATIO_DATA_SIZE  integer part of error/reference
o_fractional  output  RATIO_DATA_SIZE  fractional part (LSB = 1/256)
o_resultValid  output  1  one-cycle pulse when outputs update
o_busy  output  1  high in LATCH, DIVIDE and PUBLISH; samples are dropped
o_divByZero  output  1  last published result had reference amplitude 0

Behaviour:
- Reset (async, i_reset=1): all outputs 0. State IDLE. Window counter, min/max registers and divider cleared.
- Clocking: all state is updated on the rising edge of i_clock.
- Sample acceptance: a sample is accepted on an edge where i_sampleValid=1 and the state is ACCUMULATE.
- IDLE -> ACCUMULATE when i_enable=1.
- ACCUMULATE:
  - The first accepted sample of a window loads min=max=sample for each channel. Later samples update min and max.
  - The window counter runs 0..WINDOW_SAMPLES-1.
  - The edge that accepts sample WINDOW_SAMPLES-1 (the final update) moves the FSM to LATCH.
- LATCH (1 cycle):
  - Amplitude = max-min, zero-extended to AMPLITUDE_DATA_SIZE.
  - If the reference amplitude is 0, go to PUBLISH with divByZero. Otherwise go to DIVIDE.
- DIVIDE:
  - Numerator = errorAmp << 8 (AMPLITUDE_DATA_SIZE+8 bits), divisor = refAmp.
  - Restoring division, one quotient bit per cycle, AMPLITUDE_DATA_SIZE+8 cycles (24 at default). Then go to PUBLISH.
- PUBLISH (1 cycle):
  - Registers the amplitudes and the ratio, pulses o_resultValid, sets o_divByZero, returns to ACCUMULATE with a fresh window.
  - Ratio: if the full quotient > 0xFFFF, saturate to quotient=0xFF, fractional=0xFF. Otherwise quotient=q[15:8], fractional=q[7:0]. The fractional result truncates.
  - Divide by zero: quotient=0xFF, fractional=0xFF, o_divByZero=1. o_divByZero is cleared by the next normal publish.
- Latency, counted from the edge accepting the last sample to the edge raising o_resultValid: 26 edges at default (LATCH + 24 DIVIDE + PUBLISH); 2 edges on divide by zero.
- Outputs hold their last published values between pulses.
- Samples presented while o_busy=1 are ignored and not counted.
- i_enable=0 in any state: go to IDLE on the next edge and abort the partial window or division. No pulse is produced and published outputs hold. Re-enable starts a new window.
- i_reset mid-DIVIDE: all outputs go to 0 immediately and no pulse is produced.

Optional Feature:
AMPLITUDE_AVERAGE_EN
- Defined: in LATCH, each amplitude used for division and publishing is (previous window amplitude + current)>>1, computed with one extra bit to avoid overflow. The first window after reset or re-enable uses the current amplitude only. The previous-window registers hold raw (unaveraged) amplitudes.
- Undefined: raw per-window amplitudes are used and no previous-window registers exist. Latency is identical in both cases.

Test Plan (WINDOW_SAMPLES=8, defaults otherwise):
1. Assert i_reset mid-window -> all outputs 0 and o_busy=0 immediately; after release with i_enable=1, a full window is required before any pulse.
2. Reference alternating 100/900, error alternating 400/600, 8 samples -> refAmp=800, errAmp=200, quotient=0x00, fractional=0x40, o_resultValid pulse 26 edges after the 8th sample.
3. Reference 0/800, error 0/2400 -> quotient=0x03, fractional=0x00, o_divByZero=0; samples presented during o_busy do not affect the next window.
4. Reference constant 500, error 0/100 -> refAmp=0, quotient=0xFF, fractional=0xFF, o_divByZero=1, pulse 2 edges after the last sample.
5. Reference 500/501, error 0/4095 -> saturation: quotient=0xFF, fractional=0xFF, o_divByZero=0.
6. Drop i_enable during DIVIDE -> no pulse, outputs keep previous values; re-enable, then 8 samples -> normal pulse. With AMPLITUDE_AVERAGE_EN: reference amplitudes 800 then 400 -> second publish refAmp=600.
